// File: rtl/intack_seq.sv
// Interrupt-acknowledge sequencer: samples NMI/PIC requests at instruction boundaries,
// issues the PIC acknowledge pulse and hands the vector to the CPU.
module intack_seq #(
    parameter logic [7:0]  NMI_VECTOR = 8'h02,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       intr,
    input  logic [7:0] irq,
    input  logic       nmi,
    input  logic       if_en,
    input  logic       boundary,
    output logic       inta,
    output logic       vec_valid,
    output logic [7:0] vec,
    output logic       vec_is_nmi,
    input  logic       vec_ready
);

    typedef enum logic [1:0] {
        StIdle,
        StAck,
        StDeliver,
        StGap
    } state_e;

    localparam logic [3:0] GapLoad = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    state_e     state_q;
    logic       nmi_prev_q;
    logic       nmi_pending_q;
    logic [3:0] gap_cnt_q;
    logic       nmi_edge;

    assign nmi_edge = nmi & ~nmi_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            nmi_prev_q    <= 1'b0;
            nmi_pending_q <= 1'b0;
            gap_cnt_q     <= 4'd0;
            inta          <= 1'b0;
            vec_valid     <= 1'b0;
            vec           <= 8'h00;
            vec_is_nmi    <= 1'b0;
        end else begin
            nmi_prev_q <= nmi;
            inta       <= 1'b0;
            if (nmi_edge) begin
                nmi_pending_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (boundary && (nmi_pending_q || nmi_edge)) begin
                        // Taking the NMI overrides the set from an edge in this same cycle.
                        nmi_pending_q <= 1'b0;
                        vec           <= NMI_VECTOR;
                        vec_is_nmi    <= 1'b1;
                        vec_valid     <= 1'b1;
                        state_q       <= StDeliver;
                    end else if (boundary && intr && if_en) begin
                        // PIC drives irq=0 during inta, so the vector must be captured now.
                        vec        <= irq;
                        vec_is_nmi <= 1'b0;
                        inta       <= 1'b1;
                        state_q    <= StAck;
                    end
                end
                StAck: begin
                    vec_valid <= 1'b1;
                    state_q   <= StDeliver;
                end
                StDeliver: begin
                    if (vec_ready) begin
                        vec_valid <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            state_q <= StIdle;
                        end else begin
                            gap_cnt_q <= GapLoad;
                            state_q   <= StGap;
                        end
                    end
                end
                StGap: begin
                    if (gap_cnt_q == 4'd0) begin
                        state_q <= StIdle;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/intack_seq.md
INTACK_SEQ -- requirements
Module: intack_seq

Interface
REQ-001 SHALL have parameter NMI_VECTOR, default 8'h02, vector delivered for a non-maskable interrupt.
REQ-002 SHALL have parameter GAP_CYCLES, default 4, minimum idle cycles after a delivery before the next sample (range 0-15).
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 intr  input  1  interrupt request from the PIC (combinational in the PIC).
REQ-006 irq  input  8  vector from the PIC; valid while intr=1.
REQ-007 nmi  input  1  level NMI line; the rising edge is the event.
REQ-008 if_en  input  1  CPU interrupt-enable flag.
REQ-009 boundary  input  1  CPU at an instruction boundary; may accept an interrupt this cycle.
REQ-010 inta  output  1  one-cycle acknowledge pulse to the PIC.
REQ-011 vec_valid  output  1  vector available to the CPU.
REQ-012 vec  output  8  vector number, stable while vec_valid=1.
REQ-013 vec_is_nmi  output  1  current vector came from NMI.
REQ-014 vec_ready  input  1  CPU consumes the vector when vec_valid & vec_ready.

Function
REQ-015 SHALL implement states IDLE, ACK, DELIVER, GAP.
REQ-016 nmi_pending SHALL set on a registered rising edge of nmi (nmi=1, previous nmi=0) in any state, and clear only when an NMI vector is taken in IDLE.
REQ-017 IDLE, boundary=1 and nmi_pending (including an edge this cycle): latch vec=NMI_VECTOR, vec_is_nmi=1, clear nmi_pending, go to DELIVER; inta not asserted.
REQ-018 IDLE, boundary=1, no NMI pending, intr=1 and if_en=1: latch vec=irq this same cycle, vec_is_nmi=0, go to ACK.
REQ-019 NMI SHALL take priority over intr when both qualify in the same cycle.
REQ-020 ACK: inta=1 for exactly one cycle, then go to DELIVER; inta SHALL be a registered output, asserted only in ACK.
REQ-021 The vector SHALL be captured the cycle before inta, because the PIC records the delivered level from the prior-cycle irq and drives irq=0 during inta.
REQ-022 DELIVER: vec_valid=1; on vec_ready=1, vec_valid falls the next cycle and the state goes to GAP, or to IDLE if GAP_CYCLES=0.
REQ-023 vec_ready while vec_valid=0 SHALL be ignored.
REQ-024 GAP: 4-bit counter loaded with GAP_CYCLES-1 on entry; decrement each cycle; go to IDLE when it reaches 0; intr SHALL NOT be sampled in GAP.
REQ-025 An NMI edge during ACK, DELIVER or GAP SHALL be held pending and taken at the next qualifying IDLE boundary.
REQ-026 intr falling between the sample and ACK SHALL NOT abort the sequence; inta is still issued, since the PIC sets in-service for the delivered level.
REQ-027 if_en SHALL be ignored for NMI.
REQ-028 vec and vec_is_nmi SHALL hold their last value outside DELIVER.

Reset
REQ-029 reset SHALL force: state IDLE, inta=0, vec_valid=0, vec=0, vec_is_nmi=0, nmi_pending=0, nmi edge register=0, gap counter=0.
REQ-030 reset asserted mid-sequence (ACK or DELIVER) SHALL abandon the sequence with no further inta.
REQ-031 Outputs SHALL be valid from the first rising clk edge after reset deasserts.

Verification
REQ-032 intr=1, irq=8'h4B, if_en=1, boundary=1 at cycle N -> inta=1 at N+1 only; vec_valid=1 and vec=8'h4B from N+2 until vec_ready.
REQ-033 nmi rises together with intr=1 at a boundary -> vec=8'h02, vec_is_nmi=1, no inta; the intr sequence starts at the first boundary after GAP (4 cycles).
REQ-034 if_en=0 with intr=1 held -> no inta and vec_valid stays 0; nmi edge -> NMI delivered.
REQ-035 After vec_ready, intr=1 and boundary=1 held continuously -> next inta exactly GAP_CYCLES+2 cycles after the handshake cycle.
REQ-036 reset pulsed during DELIVER (vec=8'h21) -> vec_valid=0 and vec=0 immediately, no inta; a fresh sequence works after release.
REQ-037 Two nmi edges during one DELIVER -> exactly one NMI delivery afterwards.
